// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and 8N1 frame constants for uart_send
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: per-bit cycle counter, pulses bit_end on the last cycle of each bit
module uart_baud_cnt #(
  parameter int BPS_CNT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);
  localparam int W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign bit_end = cnt_q == W'(BPS_CNT - 1);
  always_comb cnt_d = (clr || bit_end) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_send.sv
// uart_send: 8N1 UART transmitter, frame started by a rising edge of uart_en
module uart_send
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_en,
  input  logic [7:0] uart_din,
  output logic       uart_txd,
  output logic       uart_tx_busy
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int BIT_W = $clog2(DATA_BITS);
  uart_state_e state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic txd_q, txd_d, busy_q, busy_d, en_prev_q, start, bit_end, last_bit;
  // counter is held at zero while idle so the start bit is timed from the accepting edge
  uart_baud_cnt #(.BPS_CNT(BPS_CNT)) u_baud (
    .clk(sys_clk),
    .rst(sys_rst),
    .clr(state_q == IDLE),
    .bit_end(bit_end)
  );
  assign start = uart_en & ~en_prev_q;
  assign last_bit = bit_q == BIT_W'(DATA_BITS - 1);
  assign uart_txd = txd_q;
  assign uart_tx_busy = busy_q;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    txd_d = txd_q;
    busy_d = busy_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = START;
        shift_d = uart_din;
        txd_d = 1'b0;
        busy_d = 1'b1;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d = '0;
        txd_d = shift_q[0];
        shift_d = shift_q >> 1;
      end
      DATA: if (bit_end) begin
        state_d = last_bit ? STOP : DATA;
        bit_d = bit_q + 1'b1;
        txd_d = last_bit ? 1'b1 : shift_q[0];
        shift_d = shift_q >> 1;
      end
      STOP: if (bit_end) begin
        state_d = IDLE;
        txd_d = 1'b1;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      bit_q <= '0;
      shift_q <= '0;
      txd_q <= 1'b1;
      busy_q <= 1'b0;
      en_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      txd_q <= txd_d;
      busy_q <= busy_d;
      en_prev_q <= uart_en;
    end
  end
endmodule

// File: tb/tb_uart_send.sv
// tb_uart_send: table-driven and randomized checks of uart_send against a frame-level model
module tb_uart_send;
  localparam int BPS = 16;
  logic sys_clk = 1'b0, sys_rst = 1'b1, uart_en = 1'b0;
  logic [7:0] uart_din = 8'h00;
  logic uart_txd, uart_tx_busy;
  int n_chk = 0, n_fail = 0, busy_cyc = 0;

  typedef struct {
    logic [7:0] din;
    logic [9:0] exp;
    int mode;
  } vec_t;
  vec_t vecs[8];

  always #5 sys_clk = ~sys_clk;

  uart_send #(.CLK_FREQ(16), .UART_BPS(1)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .uart_en(uart_en),
    .uart_din(uart_din),
    .uart_txd(uart_txd),
    .uart_tx_busy(uart_tx_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] line_st();
    return 32'({uart_tx_busy, uart_txd});
  endfunction

  // exp[i] is the i-th bit on the line (start, d0..d7, stop); each must last BPS cycles
  // mode 0: single-cycle pulse, 1: en/din noise while busy, 2: en held high, 3: reset mid-frame
  task automatic send(input logic [7:0] din, input logic [9:0] exp, input int mode, input string name);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    uart_din = din;
    uart_en = 1'b1;
    for (int k = 0; k < 10 * BPS; k++) begin
      @(negedge sys_clk);
      chk(name, line_st(), 32'({1'b1, exp[k / BPS]}));
      busy_cyc += uart_tx_busy ? 1 : 0;
      if (mode == 0 && k == 0) uart_en = 1'b0;
      if (mode == 1) begin
        if (k == 1) uart_din = 8'hFF;
        if (k % BPS == 3) uart_en = 1'b0;
        if (k % BPS == 8) uart_en = 1'b1;
      end
      if (mode == 3 && k == 5 * BPS + BPS / 2) begin
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk({name, "_rst"}, line_st(), 32'h1);
        sys_rst = 1'b0;
        uart_en = 1'b0;
        return;
      end
    end
    @(negedge sys_clk);
    chk({name, "_end"}, line_st(), 32'h1);
    if (mode == 1 || mode == 2) begin
      for (int k = 0; k < 40; k++) begin
        @(negedge sys_clk);
        chk({name, "_noretrig"}, line_st(), 32'h1);
      end
      uart_en = 1'b0;
    end
  endtask

  initial begin
    string hello;
    int b0;
    logic [7:0] r;
    vecs[0] = '{8'h48, 10'h290, 0};
    vecs[1] = '{8'h55, 10'h2AA, 1};
    vecs[2] = '{8'h00, 10'h200, 0};
    vecs[3] = '{8'hFF, 10'h3FE, 0};
    vecs[4] = '{8'h01, 10'h202, 0};
    vecs[5] = '{8'h80, 10'h300, 2};
    vecs[6] = '{8'hA5, 10'h34A, 3};
    vecs[7] = '{8'hA5, 10'h34A, 0};
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      chk("reset", line_st(), 32'h1);
    end
    sys_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      chk("post_reset", line_st(), 32'h1);
    end
    b0 = busy_cyc;
    send(vecs[0].din, vecs[0].exp, vecs[0].mode, "single_48");
    chk("single_busy", 32'(busy_cyc - b0), 32'd160);
    for (int i = 1; i < 8; i++) send(vecs[i].din, vecs[i].exp, vecs[i].mode, $sformatf("vec%0d", i));
    hello = "Hello World!\n";
    b0 = busy_cyc;
    for (int i = 0; i < hello.len(); i++) begin
      r = hello[i];
      send(r, {1'b1, r, 1'b0}, 0, "hello");
    end
    chk("hello_busy", 32'(busy_cyc - b0), 32'd2080);
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom);
      send(r, {1'b1, r, 1'b0}, 0, "rand");
    end
    @(negedge sys_clk);
    sys_rst = 1'b1;
    uart_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk("rst_en_high", line_st(), 32'h1);
    end
    send(8'h3C, {1'b1, 8'h3C, 1'b0}, 0, "rst_release");
    repeat (5) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
